// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the mp1 memory bridge.
// Imported by the RTL and by the testbench.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Request captured from the core in IDLE and held until the response.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_cnt <= '0;
    else if (clr)                 r_cnt <= '0;
    else if (inc && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
  end

  assign count = r_cnt;

endmodule

// File: rtl/mem_bridge.sv
// Bridges the core's held-request/mem_resp port to a req/gnt + rvalid memory,
// with a response timeout, protocol-error response and debug counters.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [3:0]       mem_byte_enable,
  input  logic [31:0]      mem_address,
  input  logic [31:0]      mem_wdata,
  output logic             mem_resp,
  output logic [31:0]      mem_rdata,
  output logic             mem_err,
  output logic             pmem_req,
  output logic             pmem_we,
  output logic [31:0]      pmem_addr,
  output logic [3:0]       pmem_be,
  output logic [31:0]      pmem_wdata,
  input  logic             pmem_gnt,
  input  logic             pmem_rvalid,
  input  logic [31:0]      pmem_rdata,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] err_count
);

  // WAIT expires on the cycle the counter would reach TIMEOUT_CYCLES.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      r_state, w_next;
  req_t        r_req;
  logic        r_err, r_resp, r_merr;
  logic [31:0] r_rdata;
  logic [15:0] r_tmo;

  logic        w_cap, w_err_d, w_enter_resp;
  logic [31:0] w_rdata_d;

  always_comb begin
    w_next    = r_state;
    w_cap     = 1'b0;
    w_err_d   = r_err;
    w_rdata_d = r_rdata;
    unique case (r_state)
      IDLE: begin
        if (mem_read ^ mem_write) begin
          w_next = REQ;
          w_cap  = 1'b1;
        end else if (mem_read && mem_write) begin
          w_next  = RESP;
          w_err_d = 1'b1;
        end
      end
      REQ:  if (pmem_gnt) w_next = WAIT;
      WAIT: begin
        // rvalid beats a simultaneous expiry
        if (pmem_rvalid) begin
          w_next    = RESP;
          w_err_d   = 1'b0;
          w_rdata_d = r_req.we ? 32'h0 : pmem_rdata;
        end else if (r_tmo == TMO_LAST) begin
          w_next    = RESP;
          w_err_d   = 1'b1;
          w_rdata_d = TIMEOUT_DATA;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_tmo   <= '0;
      r_resp  <= 1'b0;
      r_merr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_d;
      r_rdata <= w_rdata_d;
      r_resp  <= w_enter_resp;
      r_merr  <= w_enter_resp & w_err_d;
      if (w_cap) begin
        r_req.we    <= mem_write;
        r_req.addr  <= {mem_address[31:2], 2'b00};
        r_req.be    <= mem_write ? mem_byte_enable : 4'hF;
        r_req.wdata <= mem_wdata;
      end
      if (r_state == REQ && pmem_gnt) r_tmo <= '0;
      else if (r_state == WAIT)       r_tmo <= r_tmo + 16'd1;
    end
  end

  assign mem_resp   = r_resp;
  assign mem_err    = r_merr;
  assign mem_rdata  = r_rdata;
  assign pmem_req   = (r_state == REQ);
  assign pmem_we    = r_req.we;
  assign pmem_addr  = r_req.addr;
  assign pmem_be    = r_req.be;
  assign pmem_wdata = r_req.wdata;

  logic w_inc_rd, w_inc_wr, w_inc_err;
  assign w_inc_rd  = w_enter_resp & ~w_err_d & ~r_req.we;
  assign w_inc_wr  = w_enter_resp & ~w_err_d &  r_req.we;
  assign w_inc_err = w_enter_resp &  w_err_d;

  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk(clk), .rst(rst), .inc(w_inc_rd), .clr(1'b0), .count(rd_count)
  );
  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk(clk), .rst(rst), .inc(w_inc_wr), .clr(1'b0), .count(wr_count)
  );
  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .inc(w_inc_err), .clr(1'b0), .count(err_count)
  );

endmodule
